spi_master_top: RTL and testbench
=================================

# spi_master_top

Register-mapped SPI master peripheral with four 8-bit host registers (control, configuration, slave-select, data buffer). It serialises a host byte onto MOSI/SCK in any of the four SPI modes while capturing MISO into the same buffer. It sits between a simple synchronous register bus and up to eight external SPI slaves, and is verified against the `spislave_fm` slave functional model.

## Interface
- No parameters; data width is fixed at 8 bits and there are 8 slave selects.
- Clock and reset (already decided): one clock, `Clk`. Reset `Rst` is asynchronous and active-high.
- `Clk` in 1: system clock.
- `Rst` in 1: asynchronous, active-high reset.
- `Addr` in 2: register address.
- `Wr` in 1: write enable, sampled on the `Clk` rising edge.
- `DataWr` in 8: write data.
- `DataRd` out 8: read data, a combinational mux selected by `Addr`.
- `MISO` in 1: serial data from the slave.
- `MOSI` out 1: serial data to the slave.
- `SCK` out 1: SPI clock.
- `SlaveSelectors` out 8: chip selects, active-low, one per slave.

## Operation
- Register map:
  - 0 `SPI_CTRL`: bit0 Enable (R/W); bit7 Busy (read-only); bits 6:1 read 0.
  - 1 `SPI_CONFIG`: bit5 CPOL, bit4 CPHA, bits 3:0 CPre (clock prescaler); bits 7:6 read 0.
  - 2 `SPI_SSELEC`: drives `SlaveSelectors` directly.
  - 3 `SPI_BUFFER`: write loads the TX byte; read returns the last received byte, or the written byte if no transfer has happened since the write.
- Start: a write to `SPI_BUFFER` while Enable=1 and Busy=0 starts a transfer.
  - With Enable=0 the byte is stored but no transfer starts.
- While Busy=1:
  - Writes to `SPI_CONFIG` and `SPI_BUFFER` are ignored.
  - Writes to `SPI_CTRL` and `SPI_SSELEC` are accepted.
- Bit order: MSB first. 8 bits per transfer; the shift register is shared between TX and RX.
- SCK idle level = CPOL.
  - CPHA=0: MOSI presents bit7 at start; the slave samples on the leading edge; MISO is sampled on the leading edge and MOSI shifts on the trailing edge.
  - CPHA=1: MOSI shifts on the leading edge; MISO is sampled on the trailing edge.
- FSM: IDLE → SHIFT (16 SCK half-periods) → DONE (1 cycle: Busy cleared, SCK back at idle) → IDLE.
- `SlaveSelectors` is never modified by the core; the host frames CS through `SPI_SSELEC`.

## Timing
- Reset values:
  - All registers are 0, except `SPI_SSELEC` = 8'hFF (no slave selected).
  - `SCK`=0, `MOSI`=0, Busy=0.
- Register writes take effect on the `Clk` edge where `Wr`=1. `DataRd` follows `Addr` combinationally, with no added latency.
- Busy rises in the cycle after the starting `SPI_BUFFER` write.
- SCK half-period is CPre system clocks; CPre=0 is treated as 1.
  - A transfer occupies 16·max(CPre,1) cycles plus 2 cycles of overhead.
  - With CPre=2 that is 34 cycles.
- Received byte: visible in `SPI_BUFFER` in the same cycle Busy falls.
- Reset mid-transfer: aborts immediately; all registers and outputs return to their reset values.
- Enable cleared mid-transfer: the transfer completes; no new transfer can start.

## Configuration
- `SPI_LSB_FIRST_EN`:
  - Defined: `SPI_CONFIG` bit6 becomes a writable LSBF bit; LSBF=1 shifts and assembles LSB first.
  - Undefined: bit6 reads 0 and is ignored, and transfers are always MSB first.

## Structure
- Shared package `spi_pkg`:
  - Register address constants `SPI_CTRL`=0, `SPI_CONFIG`=1, `SPI_SSELEC`=2, `SPI_BUFFER`=3.
  - Bit-position constants for Enable, Busy, CPOL, CPHA, CPre, LSBF.
  - Reset value of `SPI_SSELEC`.
- One sub-module, `spi_pulse_gen`, instantiated as `pulseSPI`:
  - Input: CPre.
  - Outputs: one-cycle half-period ticks while Busy.
- The top level holds the register file, FSM and shift register.

## Test plan
- Reset, then write `SPI_CTRL`=0x01 → `SPI_CTRL` reads 0x01, `SlaveSelectors`=0xFF before the write.
- Write `SPI_SSELEC`=0xFE → reads 0xFE and `SlaveSelectors`[0]=0; write 0xFF → all high.
- `SPI_CONFIG`=0x02 (mode 0, CPre 2) → reads 0x02, and `pulseSPI.CPre`=2.
- Mode 0, CPre 2, CS0 low, write `SPI_BUFFER`=0xBB:
  - Busy reads 1 on the next cycle.
  - The slave receives 0xBB.
  - Within 50 cycles Busy=0 and `SPI_BUFFER` equals the slave's response byte (0xAA from `spislave_fm` in mode 0).
- Repeat for modes 1, 2, 3 (`SPI_CONFIG`=0x12/0x22/0x32) → `SPI_BUFFER` reads 0x72/0xC3/0x5D respectively, and SCK idles at CPOL.
- Write `SPI_BUFFER` while Busy → ignored; assert `Rst` mid-transfer → Busy=0, SCK=0, `SlaveSelectors`=0xFF.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: register map, bit positions, reset values and shift helpers shared by the SPI master.
package spi_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    localparam logic [1:0] SPI_CTRL   = 2'd0;
    localparam logic [1:0] SPI_CONFIG = 2'd1;
    localparam logic [1:0] SPI_SSELEC = 2'd2;
    localparam logic [1:0] SPI_BUFFER = 2'd3;
    localparam int EN_BIT   = 0;
    localparam int BUSY_BIT = 7;
    localparam int CPOL_BIT = 5;
    localparam int CPHA_BIT = 4;
    localparam int LSBF_BIT = 6;
    localparam int CPRE_LSB = 0;
    localparam int CPRE_MSB = 3;
    localparam int CPRE_W   = CPRE_MSB - CPRE_LSB + 1;
    localparam logic [7:0] SSELEC_RST = 8'hFF;

    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b, input logic lsbf);
        return lsbf ? {b, sr[7:1]} : {sr[6:0], b};
    endfunction

    function automatic logic [7:0] put_in(input logic [7:0] sr, input logic b, input logic lsbf);
        return lsbf ? {b, sr[6:0]} : {sr[7:1], b};
    endfunction

    function automatic logic out_bit(input logic [7:0] sr, input logic lsbf);
        return lsbf ? sr[0] : sr[7];
    endfunction
endpackage

// File: rtl/spi_pulse_gen.sv
// spi_pulse_gen: one-cycle tick every max(CPre,1) system clocks while Busy, marking SCK half-periods.
module spi_pulse_gen
    import spi_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Busy,
    input  logic [CPRE_W-1:0] CPre,
    output logic              Tick
);
    logic [CPRE_W-1:0] cnt_q, cnt_d, last;

    assign last  = (CPre == '0) ? '0 : CPre - 1'b1;
    assign Tick  = Busy && (cnt_q == last);
    assign cnt_d = (!Busy || Tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_master_top.sv
// spi_master_top: register-mapped SPI master, all four modes, shared TX/RX shift register.
// SPI_LSB_FIRST_EN makes SPI_CONFIG bit6 a writable LSB-first select.
module spi_master_top
    import spi_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] Addr,
    input  logic       Wr,
    input  logic [7:0] DataWr,
    output logic [7:0] DataRd,
    input  logic       MISO,
    output logic       MOSI,
    output logic       SCK,
    output logic [7:0] SlaveSelectors
);
`ifdef SPI_LSB_FIRST_EN
    localparam logic [7:0] CFG_MASK = 8'h7F;
`else
    localparam logic [7:0] CFG_MASK = 8'h3F;
`endif

    state_t     state_q, state_d;
    logic       en_q, en_d, sck_q, sck_d, mosi_q, mosi_d, lat_q, lat_d;
    logic [7:0] cfg_q, cfg_d, ss_q, ss_d, sr_q, sr_d;
    logic [3:0] hcnt_q, hcnt_d;
    logic       busy, tick, cpol, cpha, lsbf, lead;
    logic [7:0] sr_sh, ctrl_rd;

    assign busy  = state_q == ST_SHIFT;
    assign cpol  = cfg_q[CPOL_BIT];
    assign cpha  = cfg_q[CPHA_BIT];
    assign lsbf  = cfg_q[LSBF_BIT];
    assign lead  = !hcnt_q[0];
    assign sr_sh = shift_in(sr_q, lat_q, lsbf);

    assign SCK            = sck_q;
    assign MOSI           = mosi_q;
    assign SlaveSelectors = ss_q;

    spi_pulse_gen pulseSPI (
        .Clk  (Clk),
        .Rst  (Rst),
        .Busy (busy),
        .CPre (cfg_q[CPRE_MSB:CPRE_LSB]),
        .Tick (tick)
    );

    always_comb begin
        ctrl_rd = 8'h00;
        ctrl_rd[EN_BIT] = en_q;
        ctrl_rd[BUSY_BIT] = busy;
        DataRd = (Addr == SPI_CTRL)   ? ctrl_rd :
                 (Addr == SPI_CONFIG) ? cfg_q   :
                 (Addr == SPI_SSELEC) ? ss_q    : sr_q;
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        lat_d   = lat_q;
        cfg_d   = cfg_q;
        ss_d    = ss_q;
        sr_d    = sr_q;
        hcnt_d  = hcnt_q;
        if (Wr && Addr == SPI_CTRL) en_d = DataWr[EN_BIT];
        if (Wr && Addr == SPI_SSELEC) ss_d = DataWr;
        if (Wr && Addr == SPI_CONFIG && !busy) cfg_d = DataWr & CFG_MASK;
        if (busy) begin
            if (tick) begin
                sck_d   = ~sck_q;
                hcnt_d  = hcnt_q + 4'd1;
                state_d = (hcnt_q == 4'd15) ? ST_DONE : ST_SHIFT;
                // CPHA=0 latches MISO on the leading edge and shifts it in on the trailing one.
                if (!cpha) begin
                    lat_d  = lead ? MISO : lat_q;
                    sr_d   = lead ? sr_q : sr_sh;
                    mosi_d = lead ? mosi_q : out_bit(sr_sh, lsbf);
                end else begin
                    sr_d   = lead ? shift_in(sr_q, 1'b0, lsbf) : put_in(sr_q, MISO, lsbf);
                    mosi_d = lead ? out_bit(sr_q, lsbf) : mosi_q;
                end
            end
        end else begin
            state_d = ST_IDLE;
            sck_d   = cpol;
            if (Wr && Addr == SPI_BUFFER) begin
                sr_d = DataWr;
                if (en_q) begin
                    state_d = ST_SHIFT;
                    hcnt_d  = 4'd0;
                    mosi_d  = out_bit(DataWr, lsbf);
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            lat_q   <= 1'b0;
            cfg_q   <= 8'h00;
            ss_q    <= SSELEC_RST;
            sr_q    <= 8'h00;
            hcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            lat_q   <= lat_d;
            cfg_q   <= cfg_d;
            ss_q    <= ss_d;
            sr_q    <= sr_d;
            hcnt_q  <= hcnt_d;
        end
    end
endmodule

// File: tb/tb_spi_master_top.sv
// tb_spi_master_top: directed and random SPI transfers against a bit-level behavioural slave.
module tb_spi_master_top;
    logic       Clk = 1'b0, Rst = 1'b1, Wr = 1'b0, MISO;
    logic [1:0] Addr = 2'd0;
    logic [7:0] DataWr = 8'h00, DataRd, SlaveSelectors;
    logic       MOSI, SCK;

    int ncmp = 0, nerr = 0;

    logic       s_active = 1'b0, cpol_m = 1'b0, cpha_m = 1'b0, s_prev = 1'b0;
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
    int         s_out = 0;

    spi_master_top dut (
        .Clk(Clk), .Rst(Rst), .Addr(Addr), .Wr(Wr), .DataWr(DataWr), .DataRd(DataRd),
        .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .SlaveSelectors(SlaveSelectors)
    );

    always #5 Clk = ~Clk;

    // Slave: loads its byte when activated, then samples/shifts on SCK edges by mode.
    always @(SCK or posedge s_active) begin
        if (SCK === s_prev) begin
            s_out = 0;
            s_rx  = 8'h00;
            MISO  = cpha_m ? 1'b0 : s_tx[7];
        end else if (s_active && !SlaveSelectors[0]) begin
            if ((SCK != cpol_m) != cpha_m) s_rx = {s_rx[6:0], MOSI};
            else if (cpha_m) begin
                MISO = s_tx[3'(7 - s_out)];
                s_out++;
            end else begin
                s_out++;
                MISO = (s_out < 8) ? s_tx[3'(7 - s_out)] : 1'b0;
            end
        end
        s_prev = SCK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge Clk);
        Addr = a; DataWr = d; Wr = 1'b1;
        @(negedge Clk);
        Wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        Addr = a;
        #1 d = DataRd;
    endtask

    task automatic wait_idle(output int cnt, output logic [7:0] v);
        cnt = 1;
        rd(2'd0, v);
        while (v[7] && cnt < 400) begin
            @(negedge Clk);
            rd(2'd0, v);
            if (v[7]) cnt++;
        end
    endtask

    task automatic arm(input logic [1:0] mode, input logic [7:0] stx);
        @(negedge Clk);
        cpol_m = mode[1]; cpha_m = mode[0]; s_tx = stx;
        s_active = 1'b1;
        #1;
    endtask

    task automatic xfer(input string tag, input logic [1:0] mode, input logic [3:0] cpre,
                        input logic [7:0] tx, input logic [7:0] stx);
        logic [7:0] v;
        int cnt;
        wr(2'd1, {2'b00, mode, cpre});
        arm(mode, stx);
        chk($sformatf("%s_sck_idle", tag), SCK, cpol_m);
        wr(2'd3, tx);
        rd(2'd0, v);
        chk($sformatf("%s_busy_rise", tag), v[7], 1);
        @(negedge Clk);
        wait_idle(cnt, v);
        chk($sformatf("%s_len", tag), cnt + 1, 16 * ((cpre == 0) ? 1 : cpre));
        chk($sformatf("%s_busy_fall", tag), v[7], 0);
        rd(2'd3, v);
        chk($sformatf("%s_rx", tag), v, stx);
        chk($sformatf("%s_slave_rx", tag), s_rx, tx);
        chk($sformatf("%s_sck_end", tag), SCK, cpol_m);
        s_active = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] tx, stx;
        int cnt;
        repeat (2) @(negedge Clk);
        rd(2'd0, v); chk("rst_ctrl", v, 8'h00);
        rd(2'd1, v); chk("rst_cfg", v, 8'h00);
        rd(2'd2, v); chk("rst_ss", v, 8'hFF);
        rd(2'd3, v); chk("rst_buf", v, 8'h00);
        chk("rst_sck", SCK, 0);
        chk("rst_mosi", MOSI, 0);
        Rst = 1'b0;

        wr(2'd3, 8'h42);
        rd(2'd0, v); chk("dis_nobusy", v, 8'h00);
        rd(2'd3, v); chk("dis_buf", v, 8'h42);

        chk("ss_before", SlaveSelectors, 8'hFF);
        wr(2'd0, 8'h01);
        rd(2'd0, v); chk("ctrl_en", v, 8'h01);
        wr(2'd2, 8'hFE);
        rd(2'd2, v); chk("ss_fe", v, 8'hFE);
        chk("ss_pin0", SlaveSelectors[0], 0);
        wr(2'd2, 8'hFF);
        chk("ss_ff", SlaveSelectors, 8'hFF);
        wr(2'd1, 8'hFF);
        rd(2'd1, v);
`ifdef SPI_LSB_FIRST_EN
        chk("cfg_mask", v, 8'h7F);
`else
        chk("cfg_mask", v, 8'h3F);
`endif
        wr(2'd1, 8'h02);
        rd(2'd1, v); chk("cfg_02", v, 8'h02);
        chk("cpre_port", dut.pulseSPI.CPre, 2);
        wr(2'd2, 8'hFE);

        xfer("m0", 2'd0, 4'd2, 8'hBB, 8'hAA);
        xfer("m1", 2'd1, 4'd2, 8'hBB, 8'h72);
        xfer("m2", 2'd2, 4'd2, 8'hBB, 8'hC3);
        xfer("m3", 2'd3, 4'd2, 8'hBB, 8'h5D);

        for (int i = 0; i < 10; i++) begin
            tx  = 8'($urandom);
            stx = 8'($urandom);
            xfer($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 4)), tx, stx);
        end

        wr(2'd1, 8'h03);
        arm(2'd0, 8'h3C);
        wr(2'd3, 8'h96);
        repeat (3) @(negedge Clk);
        wr(2'd3, 8'h11);
        wr(2'd1, 8'h33);
        wr(2'd2, 8'hFC);
        rd(2'd2, v); chk("busy_ss_wr", v, 8'hFC);
        wr(2'd0, 8'h00);
        rd(2'd0, v); chk("busy_en_clr", v, 8'h80);
        wait_idle(cnt, v);
        chk("busy_done", v[7], 0);
        rd(2'd3, v); chk("busy_buf_kept", v, 8'h3C);
        rd(2'd1, v); chk("busy_cfg_kept", v, 8'h03);
        chk("busy_slave_rx", s_rx, 8'h96);
        s_active = 1'b0;
        wr(2'd3, 8'h5A);
        rd(2'd0, v); chk("en_off_nostart", v, 8'h00);
        rd(2'd3, v); chk("en_off_buf", v, 8'h5A);

        wr(2'd0, 8'h01);
        wr(2'd1, 8'h21);
        arm(2'd2, 8'h00);
        wr(2'd3, 8'hE7);
        repeat (5) @(negedge Clk);
        Rst = 1'b1;
        #1;
        rd(2'd0, v); chk("mid_rst_ctrl", v, 8'h00);
        chk("mid_rst_sck", SCK, 0);
        chk("mid_rst_mosi", MOSI, 0);
        chk("mid_rst_ss", SlaveSelectors, 8'hFF);
        rd(2'd1, v); chk("mid_rst_cfg", v, 8'h00);
        s_active = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
